// File: rtl/vip_8to10_expander.sv
// Avalon-ST video widener: 3x8-bit symbol beats in, 3x10-bit symbol beats out.
// Output register plus skid register; sink_ready comes straight from a flop.
module vip_8to10_expander #(
  parameter int unsigned EXPAND_MODE = 1,
  parameter logic [3:0]  CTRL_ID     = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [29:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        err_clear,
  output logic        err_framing
);

  localparam int unsigned SYM_IN_W  = 8;
  localparam int unsigned SYM_OUT_W = 10;
  localparam int unsigned NSYM      = 3;
  localparam int unsigned OUT_W     = SYM_OUT_W * NSYM;

  logic             in_pkt;
  logic             is_ctrl;
  logic             skid_valid;
  logic             skid_sop;
  logic             skid_eop;
  logic [OUT_W-1:0] skid_data;

  logic             accept;
  logic             emit;
  logic             beat_ctrl;
  logic             use_zx;
  logic             skid_next;
  logic             err_set;
  logic [OUT_W-1:0] mapped;

  // Sop beats and control packets keep numeric value; video symbols widen to full range.
  function automatic logic [SYM_OUT_W-1:0] widen(input logic [SYM_IN_W-1:0] s, input logic zx);
    logic [SYM_OUT_W-1:0] r;
    if (zx)                    r = {2'b00, s};
    else if (EXPAND_MODE != 0) r = {s, s[7:6]};
    else                       r = {s, 2'b00};
    return r;
  endfunction

  always_comb begin
    accept    = sink_valid & sink_ready;
    emit      = source_valid & source_ready;
    beat_ctrl = sink_sop & (sink_data[3:0] == CTRL_ID);
    use_zx    = sink_sop | is_ctrl;
    mapped    = '0;
    for (int i = 0; i < int'(NSYM); i++) begin
      mapped[i*SYM_OUT_W +: SYM_OUT_W] = widen(sink_data[i*SYM_IN_W +: SYM_IN_W], use_zx);
    end
    skid_next = skid_valid ? ~emit : (accept & source_valid & ~source_ready);
    err_set   = accept & (sink_sop ? in_pkt : ~in_pkt);
  end

  // OUT/SKID pipeline; accept never coincides with skid_valid since sink_ready == ~skid_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      source_data  <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      skid_data    <= '0;
      skid_valid   <= 1'b0;
      skid_sop     <= 1'b0;
      skid_eop     <= 1'b0;
      sink_ready   <= 1'b1;
    end else begin
      if (emit && skid_valid) begin
        source_data <= skid_data;
        source_sop  <= skid_sop;
        source_eop  <= skid_eop;
      end else if (accept && (!source_valid || emit)) begin
        source_data  <= mapped;
        source_sop   <= sink_sop;
        source_eop   <= sink_eop;
        source_valid <= 1'b1;
      end else if (accept) begin
        skid_data <= mapped;
        skid_sop  <= sink_sop;
        skid_eop  <= sink_eop;
      end else if (emit) begin
        source_valid <= 1'b0;
      end
      skid_valid <= skid_next;
      sink_ready <= ~skid_next;
    end
  end

  // Framing tracker and sticky error; a new error outranks err_clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_pkt      <= 1'b0;
      is_ctrl     <= 1'b0;
      err_framing <= 1'b0;
    end else begin
      if (accept) begin
        if (sink_sop) begin
          in_pkt  <= ~sink_eop;
          is_ctrl <= beat_ctrl & ~sink_eop;
        end else if (sink_eop) begin
          in_pkt  <= 1'b0;
          is_ctrl <= 1'b0;
        end
      end
      err_framing <= err_set | (err_framing & ~err_clear);
    end
  end

endmodule

// File: tb/tb_vip_8to10_expander.sv
// Directed and throttled-stream bench for vip_8to10_expander (both EXPAND_MODE settings).
module tb_vip_8to10_expander;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [23:0] d;
    logic [29:0] x;
  } beat_t;

  logic        clk;
  logic        reset_n;
  logic [23:0] sink_data;
  logic        sink_valid;
  logic        sink_sop;
  logic        sink_eop;
  logic        source_ready;
  logic        err_clear;

  logic        sink_ready,  sink_ready0;
  logic [29:0] source_data, source_data0;
  logic        source_valid, source_valid0;
  logic        source_sop,  source_sop0;
  logic        source_eop,  source_eop0;
  logic        err_framing, err_framing0;

  int          checks;
  int          failures;
  beat_t       q[$];
  beat_t       b;
  int          nb;
  logic        ctrl;

  vip_8to10_expander #(.EXPAND_MODE(1), .CTRL_ID(4'hF)) dut (
    .clk(clk), .reset_n(reset_n),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop),
    .err_clear(err_clear), .err_framing(err_framing)
  );

  vip_8to10_expander #(.EXPAND_MODE(0), .CTRL_ID(4'hF)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready0),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .source_data(source_data0), .source_valid(source_valid0), .source_ready(source_ready),
    .source_sop(source_sop0), .source_eop(source_eop0),
    .err_clear(err_clear), .err_framing(err_framing0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference widening used only to build stream expectations.
  function automatic logic [29:0] bmap(input logic [23:0] d, input logic zx);
    logic [29:0] r;
    logic [7:0]  s;
    for (int i = 0; i < 3; i++) begin
      s = d[i*8 +: 8];
      r[i*10 +: 10] = zx ? {2'b00, s} : {s, s[7:6]};
    end
    return r;
  endfunction

  // Drives q through the DUT and checks every emitted beat in order.
  task automatic run_queue(input int max_cyc, input bit rnd);
    int   gi;
    int   oi;
    int   cyc;
    logic acc;
    logic emt;
    logic exp_rdy [2:6];
    gi = 0; oi = 0; cyc = 0;
    exp_rdy[2] = 1'b1; exp_rdy[3] = 1'b0; exp_rdy[4] = 1'b0; exp_rdy[5] = 1'b0; exp_rdy[6] = 1'b1;
    while (oi < q.size() && cyc < max_cyc) begin
      if (!sink_valid && gi < q.size()) sink_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
      if (sink_valid) begin
        sink_data = q[gi].d; sink_sop = q[gi].sop; sink_eop = q[gi].eop;
      end
      source_ready = rnd ? ($urandom_range(3) != 0) : !(cyc >= 3 && cyc <= 5);
      if (!rnd && cyc >= 1) check("stall_no_gap", 32'(source_valid), 32'd1);
      acc = sink_valid & sink_ready;
      emt = source_valid & source_ready;
      if (emt) begin
        check("stream_beat", {source_sop, source_eop, source_data}, {q[oi].sop, q[oi].eop, q[oi].x});
        oi++;
      end
      step();
      if (acc) begin
        gi++;
        sink_valid = 1'b0;
      end
      if (!rnd && cyc >= 2 && cyc <= 6) check("stall_sink_ready", 32'(sink_ready), 32'(exp_rdy[cyc]));
      cyc++;
    end
    sink_valid = 1'b0;
    check("stream_count", 32'(oi), 32'(q.size()));
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; sink_data = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    source_ready = 1'b1; err_clear = 1'b0;
    step(); step();
    check("rst_source_valid", 32'(source_valid), 32'd0);
    check("rst_sink_ready", 32'(sink_ready), 32'd1);
    check("rst_source_data", 32'(source_data), 32'd0);
    check("rst_err", 32'(err_framing), 32'd0);
    reset_n = 1'b1;
    step();

    // Video packet, 1 clk latency
    sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b0; sink_data = 24'h000000;
    step();
    check("vid_sop_valid", 32'(source_valid), 32'd1);
    check("vid_sop_beat", {source_sop, source_eop, source_data}, {2'b10, 30'h0});
    sink_sop = 1'b0; sink_eop = 1'b1; sink_data = 24'hFF8040;
    step();
    check("vid_data_beat", {source_sop, source_eop, source_data}, {2'b01, 10'h3FF, 10'h202, 10'h101});
    check("vid_mode0_beat", 32'(source_data0), 32'({10'h3FC, 10'h200, 10'h100}));
    sink_valid = 1'b0;
    step();
    check("vid_drain", 32'(source_valid), 32'd0);

    // Control packet passes numerically unchanged
    sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b0; sink_data = 24'h00000F;
    step();
    check("ctrl_sop_beat", {source_sop, source_eop, source_data}, {2'b10, 30'h00F});
    sink_sop = 1'b0; sink_eop = 1'b1; sink_data = 24'hFF8040;
    step();
    check("ctrl_data_beat", {source_sop, source_eop, source_data}, {2'b01, 10'h0FF, 10'h080, 10'h040});
    check("ctrl_mode0_beat", 32'(source_data0), 32'({10'h0FF, 10'h080, 10'h040}));

    // Zero-append mode on full-scale video
    sink_sop = 1'b1; sink_eop = 1'b0; sink_data = 24'h000000;
    step();
    sink_sop = 1'b0; sink_eop = 1'b1; sink_data = 24'hFFFFFF;
    step();
    check("mode0_full_scale", {source_sop0, source_eop0, source_data0}, {2'b01, 10'h3FC, 10'h3FC, 10'h3FC});
    check("mode1_full_scale", 32'(source_data), 32'({10'h3FF, 10'h3FF, 10'h3FF}));
    sink_valid = 1'b0;
    step();

    // Backpressure: 8-beat packet with a 3-clk output stall
    q.delete();
    for (int i = 0; i < 8; i++) begin
      b.d   = {3{8'(i * 17 + 32)}};
      b.sop = (i == 0);
      b.eop = (i == 7);
      b.x   = bmap(b.d, b.sop);
      q.push_back(b);
    end
    run_queue(40, 1'b0);
    source_ready = 1'b1;
    check("stall_no_err", 32'(err_framing), 32'd0);

    // Framing error, clear, and clear losing to a new error
    sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b0; sink_data = 24'h000001;
    step();
    check("err_first_sop", 32'(err_framing), 32'd0);
    sink_data = 24'h000002;
    step();
    check("err_sop_midpkt", 32'(err_framing), 32'd1);
    sink_valid = 1'b0; err_clear = 1'b1;
    step();
    check("err_cleared", 32'(err_framing), 32'd0);
    sink_valid = 1'b1; sink_data = 24'h000003;
    step();
    check("err_clear_vs_new", 32'(err_framing), 32'd1);
    sink_valid = 1'b0;
    step();
    err_clear = 1'b0;
    check("err_cleared2", 32'(err_framing), 32'd0);
    sink_valid = 1'b1; sink_sop = 1'b0; sink_eop = 1'b1; sink_data = 24'h000004;
    step();
    check("err_clean_eop", 32'(err_framing), 32'd0);
    sink_data = 24'h808080;
    step();
    check("err_outside_pkt", 32'(err_framing), 32'd1);
    check("outside_pkt_video", {source_sop, source_eop, source_data}, {2'b01, 10'h202, 10'h202, 10'h202});
    sink_valid = 1'b0; err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("err_cleared3", 32'(err_framing), 32'd0);

    // Async reset with OUT and SKID full
    source_ready = 1'b0;
    sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b0; sink_data = 24'h123456;
    step();
    sink_sop = 1'b0; sink_data = 24'h654321;
    step();
    check("full_sink_ready", 32'(sink_ready), 32'd0);
    sink_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_source_valid", 32'(source_valid), 32'd0);
    check("arst_sink_ready", 32'(sink_ready), 32'd1);
    #1 reset_n = 1'b1;
    source_ready = 1'b1;
    step();
    sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b0; sink_data = 24'h000000;
    step();
    check("post_rst_sop", {source_sop, source_eop, source_data}, {2'b10, 30'h0});
    sink_sop = 1'b0; sink_eop = 1'b1; sink_data = 24'hFF8040;
    step();
    check("post_rst_data", {source_sop, source_eop, source_data}, {2'b01, 10'h3FF, 10'h202, 10'h101});
    sink_valid = 1'b0;
    step();
    check("post_rst_drain", 32'(source_valid), 32'd0);
    check("post_rst_err", 32'(err_framing), 32'd0);

    // Throttled stream of mixed control/video packets
    q.delete();
    for (int p = 0; p < 1000; p++) begin
      ctrl = ($urandom_range(3) == 0);
      nb   = $urandom_range(4, 1);
      for (int i = 0; i < nb; i++) begin
        b.d   = 24'($urandom);
        b.sop = (i == 0);
        b.eop = (i == nb - 1);
        if (b.sop) b.d[3:0] = ctrl ? 4'hF : ((b.d[3:0] == 4'hF) ? 4'h0 : b.d[3:0]);
        b.x   = bmap(b.d, b.sop | ctrl);
        q.push_back(b);
      end
    end
    run_queue(60000, 1'b1);
    check("rand_no_err", 32'(err_framing), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
